// File: rtl/hsk4_pkg.sv
// Shared types and elaboration helpers for the 4-phase handshake transmitter.
package hsk4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } hsk4_st_t;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/hsk4_fifo.sv
// Single-clock input FIFO; full is reported from occupancy alone, so a pop in the
// same cycle never re-opens the write side.
module hsk4_fifo
   import hsk4_pkg::*;
#(
   parameter  int DW    = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   output logic [DW-1:0] dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] lvl_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (lvl_q == LW'(DEPTH));
   assign empty_o = (lvl_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q];
   assign lvl_o   = lvl_q;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      // DEPTH is a power of two, so natural pointer overflow is the wrap
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   lvl_d = lvl_q + LW'(1);
         2'b01:   lvl_d = lvl_q - LW'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

endmodule

// File: rtl/hsk4_tx.sv
// 4-phase vld/rdy source: buffers a per-beat upstream stream and presents one word
// at a time to the CDC synchroniser's src side, with an optional per-phase timeout.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no word in flight; loads the FIFO head when one is available
//   REQ   | out_vld high, waiting for the peer to raise out_rdy
//   REL   | out_vld low, waiting for the peer to drop out_rdy
module hsk4_tx
   import hsk4_pkg::*;
#(
   parameter int DW     = 32,
   parameter int DEPTH  = 4,
   parameter int TO_CYC = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  logic [DW-1:0]                in_dat,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [DW-1:0]                out_dat,
   output logic [$clog2(DEPTH+1)-1:0]   lvl,
   output logic                         busy,
   input  logic                         clr_err,
   output logic                         timeout_err
);

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("hsk4_tx: DEPTH must be a power of two and at least 2");
   end

   hsk4_st_t      st_q, st_d;
   logic          vld_q, vld_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          err_q, err_d;
   logic          pop;
   logic          to_set;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;

   hsk4_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_vld),
      .din_i   (in_dat),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .lvl_o   (lvl)
   );

   assign in_rdy = !fifo_full;

   always_comb begin
      st_d  = st_q;
      vld_d = vld_q;
      dat_d = dat_q;
      pop   = 1'b0;
      case (st_q)
         IDLE: begin
            vld_d = 1'b0;
            if (!fifo_empty) begin
               pop   = 1'b1;
               dat_d = fifo_dout;
               vld_d = 1'b1;
               st_d  = REQ;
            end
         end
         REQ: begin
            vld_d = 1'b1;
            if (out_rdy) begin
               vld_d = 1'b0;
               st_d  = REL;
            end
         end
         REL: begin
            vld_d = 1'b0;
            if (!out_rdy) st_d = IDLE;
         end
         default: begin
            vld_d = 1'b0;
            st_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         st_q  <= st_d;
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   if (TO_CYC > 0) begin : g_to
      localparam int CW = $clog2(TO_CYC + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          st_chg;

      assign st_chg = (st_d != st_q);

      always_comb begin
         cnt_d = cnt_q;
         if (st_chg || st_q == IDLE) cnt_d = '0;
         else if (cnt_q != CW'(TO_CYC)) cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk) begin
         if (rst) cnt_q <= '0;
         else     cnt_q <= cnt_d;
      end

      // fires once, on the edge where the counter reaches TO_CYC
      assign to_set = (st_q != IDLE) && !st_chg && (cnt_q == CW'(TO_CYC - 1));
   end else begin : g_no_to
      assign to_set = 1'b0;
   end

   always_comb begin
      err_d = err_q;
      if (to_set)       err_d = 1'b1;
      else if (clr_err) err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   // reset must release the peer at once, not one edge later
   assign out_vld     = vld_q && !rst;
   assign out_dat     = dat_q;
   assign busy        = (st_q != IDLE);
   assign timeout_err = err_q;

endmodule

// File: tb/tb_hsk4_tx.sv
// Self-checking bench for hsk4_tx: peer model with programmable ack latencies plus
// a scoreboard of accepted words compared at each out_vld rising edge.
module tb_hsk4_tx;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TOC   = 16;

   logic          clk;
   logic          rst;
   logic          in_vld;
   logic          in_rdy;
   logic [DW-1:0] in_dat;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] out_dat;
   logic [2:0]    lvl;
   logic          busy;
   logic          clr_err;
   logic          timeout_err;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            rx_cnt  = 0;
   logic [DW-1:0] exp_q [$];
   int            peer_k  = 1;
   int            peer_j  = 1;
   bit            peer_stuck = 0;

   hsk4_tx #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .TO_CYC (TOC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_vld      (in_vld),
      .in_rdy      (in_rdy),
      .in_dat      (in_dat),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_dat     (out_dat),
      .lvl         (lvl),
      .busy        (busy),
      .clr_err     (clr_err),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Peer: raises rdy peer_k cycles after seeing vld, drops it peer_j cycles after vld falls.
   initial begin : peer
      int cnt;
      cnt     = 0;
      out_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            out_rdy = 1'b0;
            cnt     = 0;
         end else if (!out_rdy) begin
            if (out_vld) begin
               if (cnt >= peer_k) begin
                  out_rdy = 1'b1;
                  cnt     = 0;
               end else cnt++;
            end else cnt = 0;
         end else if (!out_vld && !peer_stuck) begin
            if (cnt >= peer_j) begin
               out_rdy = 1'b0;
               cnt     = 0;
            end else cnt++;
         end
      end
   end

   // Monitor: scoreboard pop on every out_vld rise plus protocol and stability checks.
   logic          prev_vld     = 1'b0;
   bit            rdy_low_seen = 1'b1;
   logic [DW-1:0] cur_dat      = '0;
   always @(negedge clk) begin
      if (out_vld && !prev_vld) begin
         n_tests++;
         if (!rdy_low_seen) begin
            n_fail++;
            $display("FAIL proto_rise: out_vld rose again without out_rdy low in between, got 0 required 1");
         end
         rdy_low_seen = 1'b0;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: out_vld rose with data %h, required no word (scoreboard empty)", out_dat);
         end else begin
            cur_dat = exp_q.pop_front();
            if (out_dat !== cur_dat) begin
               n_fail++;
               $display("FAIL sb_data: got %h, expected %h", out_dat, cur_dat);
            end
         end
         rx_cnt++;
      end else if (out_vld && prev_vld) begin
         n_tests++;
         if (out_dat !== cur_dat) begin
            n_fail++;
            $display("FAIL dat_stable: got %h, expected %h", out_dat, cur_dat);
         end
      end
      if (!out_vld && !out_rdy) rdy_low_seen = 1'b1;
      prev_vld = out_vld;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_word(input logic [DW-1:0] d);
      bit acc;
      acc    = 1'b0;
      in_vld = 1'b1;
      in_dat = d;
      for (int t = 0; t < 300 && !acc; t++) begin
         acc = in_rdy;
         @(posedge clk);
         #1;
      end
      in_vld = 1'b0;
      if (acc) exp_q.push_back(d);
      else begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: in_rdy got 0 for 300 cycles, required 1");
      end
   endtask

   task automatic wait_drain(input int budget, input string name);
      int t;
      t = 0;
      while (t < budget && (exp_q.size() != 0 || busy !== 1'b0 || lvl !== 3'd0)) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (exp_q.size() != 0 || busy !== 1'b0 || lvl !== 3'd0) begin
         n_fail++;
         $display("FAIL %s_drain: got pending=%0d busy=%b lvl=%0d, required 0 0 0",
                  name, exp_q.size(), busy, lvl);
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      in_vld  = 1'b0;
      in_dat  = '0;
      clr_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld: got %b, expected 0", out_vld); end
      n_tests++; if (out_dat !== '0) begin n_fail++; $display("FAIL rst_out_dat: got %h, expected 0", out_dat); end
      n_tests++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL rst_lvl: got %0d, expected 0", lvl); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, expected 0", timeout_err); end
      n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_in_rdy: got %b, expected 1", in_rdy); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      peer_k = 1;
      peer_j = 1;
      @(posedge clk);
      #1;
      in_vld = 1'b1;
      in_dat = 32'hDEADBEEF;
      exp_q.push_back(32'hDEADBEEF);
      @(posedge clk);
      #1 in_vld = 1'b0;
      @(negedge clk);
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_early_vld: got %b, expected 0", out_vld); end
      n_tests++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL single_lvl: got %0d, expected 1", lvl); end
      @(negedge clk);
      n_tests++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld_rise: got %b, expected 1", out_vld); end
      n_tests++; if (out_dat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_dat: got %h, expected deadbeef", out_dat); end
      for (int t = 0; t < 20 && !out_rdy; t++) @(negedge clk);
      n_tests++; if (out_rdy !== 1'b1) begin n_fail++; $display("FAIL single_ack_wait: out_rdy got %b, expected 1", out_rdy); end
      @(negedge clk);
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld_fall: got %b, expected 0", out_vld); end
      for (int t = 0; t < 20 && out_rdy; t++) @(negedge clk);
      @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, expected 0", busy); end
      wait_drain(50, "single");
   endtask

   task automatic test_burst();
      bit saw_full;
      bit acc;
      saw_full = 1'b0;
      peer_k   = 3;
      peer_j   = 2;
      for (int i = 0; i < 8; i++) begin
         acc    = 1'b0;
         in_vld = 1'b1;
         in_dat = 32'hB0B0_0000 + DW'(i);
         for (int t = 0; t < 200 && !acc; t++) begin
            if (lvl == 3'd4) begin
               saw_full = 1'b1;
               n_tests++;
               if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL burst_full_rdy: got %b, expected 0", in_rdy); end
            end
            acc = in_rdy;
            @(posedge clk);
            #1;
         end
         in_vld = 1'b0;
         if (acc) exp_q.push_back(32'hB0B0_0000 + DW'(i));
         else begin n_tests++; n_fail++; $display("FAIL burst_push_timeout: word %0d not accepted", i); end
      end
      n_tests++; if (!saw_full) begin n_fail++; $display("FAIL burst_fill: lvl reached 4 got 0, expected 1"); end
      wait_drain(400, "burst");
   endtask

   task automatic test_stuck();
      peer_k     = 1;
      peer_j     = 1;
      peer_stuck = 1'b1;
      push_word(32'h5100_0001);
      push_word(32'h5100_0002);
      for (int t = 0; t < 40 && !(out_rdy && !out_vld && busy); t++) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i < 8) begin
            n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL stuck_vld: got %b, expected 0", out_vld); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stuck_busy: got %b, expected 1", busy); end
            n_tests++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL stuck_lvl: got %0d, expected 1", lvl); end
         end
      end
      n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL stuck_rel_timeout: got %b, expected 1", timeout_err); end
      peer_stuck = 1'b0;
      wait_drain(100, "stuck");
      @(negedge clk);
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL stuck_clr: got %b, expected 0", timeout_err); end
   endtask

   task automatic test_timeout();
      peer_k = 100000;
      @(posedge clk);
      #1;
      in_vld = 1'b1;
      in_dat = 32'h7100_00AA;
      exp_q.push_back(32'h7100_00AA);
      @(posedge clk);
      #1 in_vld = 1'b0;
      @(posedge clk);
      repeat (15) @(posedge clk);
      @(negedge clk);
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b, expected 0", timeout_err); end
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set_wins: got %b, expected 1", timeout_err); end
      n_tests++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL to_vld_held: got %b, expected 1", out_vld); end
      repeat (5) @(negedge clk);
      n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b, expected 1", timeout_err); end
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b, expected 0", timeout_err); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy: got %b, expected 1", busy); end
      peer_k = 1;
      wait_drain(60, "timeout");
   endtask

   task automatic test_reset_mid();
      peer_k = 100000;
      push_word(32'hC0DE_0000);
      push_word(32'hC0DE_0001);
      push_word(32'hC0DE_0002);
      push_word(32'hC0DE_0003);
      @(negedge clk);
      n_tests++; if (lvl !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_lvl: got %0d, expected 3", lvl); end
      n_tests++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_vld: got %b, expected 1", out_vld); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      peer_k = 1;
      @(negedge clk);
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_vld: got %b, expected 0", out_vld); end
      n_tests++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL rmid_lvl: got %0d, expected 0", lvl); end
      n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_in_rdy: got %b, expected 1", in_rdy); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
      n_tests++; if (out_dat !== '0) begin n_fail++; $display("FAIL rmid_dat: got %h, expected 0", out_dat); end
      repeat (3) @(negedge clk);
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_no_replay: got %b, expected 0", out_vld); end
   endtask

   task automatic test_random();
      int start;
      start = rx_cnt;
      for (int i = 0; i < 1000; i++) begin
         peer_k = int'($urandom_range(0, 7));
         peer_j = int'($urandom_range(0, 7));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         push_word($urandom);
      end
      wait_drain(2000, "random");
      n_tests++; if (rx_cnt - start != 1000) begin n_fail++; $display("FAIL rand_count: got %0d, expected 1000", rx_cnt - start); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b, expected 0", timeout_err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_stuck();
      test_timeout();
      test_reset_mid();
      test_random();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
